// File: rtl/obuf_pkg.sv
// Shared constants and FSM state type for the deskewing output buffer.
package obuf_pkg;

    localparam int OBUF_LANES  = 16;
    localparam int OBUF_LANE_W = 64;
    localparam int OBUF_DEPTH  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } obuf_state_e;

endpackage

// File: rtl/obuf_bank.sv
// One lane of storage: DEPTH x W array, one write port, one clear port
// and a registered read that returns pre-write contents.
module obuf_bank #(
    parameter int DEPTH = 32,
    parameter int W     = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          clr,
    input  logic [AW-1:0] caddr,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_reg;

    // The write is scheduled after the clear so it wins on an address collision.
    always_ff @(posedge CLK) begin
        if (clr) begin
            mem[caddr] <= '0;
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/output_buffer_skew.sv
// Deskewing output buffer: lane i of a write lands at row A-i, rows are read
// singly or drained with ready/valid. Define OBUF_CLEAR_ON_DRAIN_EN to zero rows as they drain.
module output_buffer_skew
    import obuf_pkg::*;
#(
    parameter int LANES  = OBUF_LANES,
    parameter int LANE_W = OBUF_LANE_W,
    parameter int DEPTH  = OBUF_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                    CLK,
    input  logic                    RETN,
    input  logic                    CEN,
    input  logic                    WEN,
    input  logic [AW-1:0]           A,
    input  logic [LANES*LANE_W-1:0] D,
    input  logic [LANES-1:0]        LMASK,
    output logic [LANES*LANE_W-1:0] Q,
    output logic                    QV,
    input  logic                    DRAIN_START,
    input  logic [AW-1:0]           DRAIN_BASE,
    input  logic [AW:0]             DRAIN_LEN,
    input  logic                    DRAIN_READY,
    output logic                    DRAIN_BUSY,
    output logic                    DRAIN_DONE
);

    obuf_state_e state_reg;
    logic [AW-1:0] ptr_reg;
    logic [AW:0]   cnt_reg;
    logic [AW:0]   issue_left_reg;
    logic          qv_reg;

    logic          wr_req;
    logic          rd_issue;
    logic          drain_issue;
    logic          accept;
    logic          beat;
    logic          clr_en;
    logic [AW-1:0] rd_addr;
    logic [LANES*LANE_W-1:0] bank_q;

    assign wr_req      = !CEN && !WEN;
    // A drain request wins over a read offered in the same idle cycle.
    assign rd_issue    = (state_reg == ST_IDLE) && !CEN && WEN && !DRAIN_START;
    assign drain_issue = (state_reg == ST_DRAIN) && (issue_left_reg != '0)
                         && (!qv_reg || DRAIN_READY);
    assign accept      = (state_reg == ST_DRAIN) && qv_reg && DRAIN_READY;
    assign beat        = rd_issue || drain_issue;
    assign rd_addr     = drain_issue ? ptr_reg : A;

`ifdef OBUF_CLEAR_ON_DRAIN_EN
    assign clr_en = drain_issue;
`else
    assign clr_en = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RETN) begin
        if (!RETN) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            cnt_reg        <= '0;
            issue_left_reg <= '0;
            qv_reg         <= 1'b0;
        end else begin
            // Valid persists only while a drain beat is stalled downstream.
            qv_reg <= beat || (qv_reg && !DRAIN_READY && (state_reg == ST_DRAIN));
            case (state_reg)
                ST_IDLE: begin
                    if (DRAIN_START) begin
                        ptr_reg        <= DRAIN_BASE;
                        cnt_reg        <= DRAIN_LEN;
                        issue_left_reg <= DRAIN_LEN;
                        state_reg      <= (DRAIN_LEN == '0) ? ST_DONE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_issue) begin
                        ptr_reg        <= ptr_reg + AW'(1);
                        issue_left_reg <= issue_left_reg - (AW+1)'(1);
                    end
                    if (accept) begin
                        cnt_reg <= cnt_reg - (AW+1)'(1);
                        if (cnt_reg == (AW+1)'(1)) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [AW-1:0] waddr;
            assign waddr = A - AW'(gi);

            obuf_bank #(
                .DEPTH (DEPTH),
                .W     (LANE_W),
                .AW    (AW)
            ) u_bank (
                .CLK   (CLK),
                .we    (wr_req && LMASK[gi]),
                .waddr (waddr),
                .wdata (D[gi*LANE_W +: LANE_W]),
                .clr   (clr_en),
                .caddr (ptr_reg),
                .re    (beat),
                .raddr (rd_addr),
                .rdata (bank_q[gi*LANE_W +: LANE_W])
            );
        end
    endgenerate

    assign Q          = qv_reg ? bank_q : '0;
    assign QV         = qv_reg;
    assign DRAIN_BUSY = (state_reg != ST_IDLE);
    assign DRAIN_DONE = (state_reg == ST_DONE);

endmodule

// File: tb/tb_output_buffer_skew.sv
// Directed bench for output_buffer_skew; honours OBUF_CLEAR_ON_DRAIN_EN when defined.
module tb_output_buffer_skew;

    localparam int LANES  = 16;
    localparam int LANE_W = 64;
    localparam int DEPTH  = 32;
    localparam int AW     = 5;
    localparam int DW     = LANES * LANE_W;

    logic          CLK = 1'b0;
    logic          RETN;
    logic          CEN;
    logic          WEN;
    logic [AW-1:0] A;
    logic [DW-1:0] D;
    logic [LANES-1:0] LMASK;
    logic [DW-1:0] Q;
    logic          QV;
    logic          DRAIN_START;
    logic [AW-1:0] DRAIN_BASE;
    logic [AW:0]   DRAIN_LEN;
    logic          DRAIN_READY;
    logic          DRAIN_BUSY;
    logic          DRAIN_DONE;

    logic [LANE_W-1:0] model [DEPTH][LANES];
    int n_checks = 0;
    int n_fail   = 0;

    output_buffer_skew #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RETN        (RETN),
        .CEN         (CEN),
        .WEN         (WEN),
        .A           (A),
        .D           (D),
        .LMASK       (LMASK),
        .Q           (Q),
        .QV          (QV),
        .DRAIN_START (DRAIN_START),
        .DRAIN_BASE  (DRAIN_BASE),
        .DRAIN_LEN   (DRAIN_LEN),
        .DRAIN_READY (DRAIN_READY),
        .DRAIN_BUSY  (DRAIN_BUSY),
        .DRAIN_DONE  (DRAIN_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_idle;
        CEN = 1'b1; WEN = 1'b1; A = '0; D = '0; LMASK = '0;
        DRAIN_START = 1'b0; DRAIN_BASE = '0; DRAIN_LEN = '0; DRAIN_READY = 1'b0;
    endtask

    function automatic logic [DW-1:0] model_row(input int r);
        logic [DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*LANE_W +: LANE_W] = model[r][i];
        return v;
    endfunction

    function automatic logic [LANE_W-1:0] lane_of(input logic [DW-1:0] v, input int i);
        return v[i*LANE_W +: LANE_W];
    endfunction

    function automatic int diff_lane(input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int i = 0; i < LANES; i++)
            if (a[i*LANE_W +: LANE_W] !== b[i*LANE_W +: LANE_W]) return i;
        return 0;
    endfunction

`ifdef OBUF_CLEAR_ON_DRAIN_EN
    task automatic model_clear(input int r);
        for (int i = 0; i < LANES; i++) model[r % DEPTH][i] = '0;
    endtask
`endif

    task automatic do_write(input int a, input logic [LANES-1:0] m, input logic [DW-1:0] d);
        logic [AW-1:0] r;
        CEN = 1'b0; WEN = 1'b0; A = AW'(a); LMASK = m; D = d;
        for (int i = 0; i < LANES; i++) begin
            if (m[i]) begin
                r = AW'(a) - AW'(i);
                model[r][i] = d[i*LANE_W +: LANE_W];
            end
        end
        tick;
        CEN = 1'b1; WEN = 1'b1; LMASK = '0;
    endtask

    task automatic do_read(input int r, output logic [DW-1:0] q1, output logic qv1,
                           output logic [DW-1:0] q2, output logic qv2);
        CEN = 1'b0; WEN = 1'b1; A = AW'(r);
        tick;
        CEN = 1'b1;
        q1 = Q; qv1 = QV;
        tick;
        q2 = Q; qv2 = QV;
    endtask

    task automatic test_reset;
        set_idle;
        RETN = 1'b0;
        #3;
        n_checks++;
        if (Q !== '0 || QV !== 1'b0) begin
            n_fail++; $display("FAIL reset_q: got qv=%b q_nonzero=%b expected qv=0 q=0", QV, (Q != '0));
        end
        n_checks++;
        if (DRAIN_BUSY !== 1'b0 || DRAIN_DONE !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", DRAIN_BUSY, DRAIN_DONE);
        end
        tick; tick;
        RETN = 1'b1;
        tick;
        n_checks++;
        if (QV !== 1'b0 || DRAIN_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got qv=%b busy=%b expected 0 0", QV, DRAIN_BUSY);
        end
        $display("test_reset done");
    endtask

    task automatic test_fill;
        logic [DW-1:0] d, q1, q2;
        logic qv1, qv2;
        logic [AW-1:0] r;
        for (int a = 0; a < DEPTH; a++) begin
            for (int i = 0; i < LANES; i++) begin
                r = AW'(a) - AW'(i);
                d[i*LANE_W +: LANE_W] = 64'hF000_0000_0000_0000 | (64'(r) << 32) | 64'(i);
            end
            do_write(a, '1, d);
        end
        for (int k = 0; k < 3; k++) begin
            int row;
            row = (k == 0) ? 0 : ((k == 1) ? 17 : 31);
            do_read(row, q1, qv1, q2, qv2);
            n_checks++;
            if (qv1 !== 1'b1 || q1 !== model_row(row)) begin
                n_fail++;
                $display("FAIL fill_row%0d: got qv=%b lane%0d=%h expected qv=1 lane=%h", row, qv1,
                         diff_lane(q1, model_row(row)), lane_of(q1, diff_lane(q1, model_row(row))),
                         lane_of(model_row(row), diff_lane(q1, model_row(row))));
            end
            $display("fill read row %0d qv=%b", row, qv1);
        end
    endtask

    task automatic test_skew;
        logic [DW-1:0] d, q1, q2;
        logic qv1, qv2;
        for (int i = 0; i < LANES; i++) d[i*LANE_W +: LANE_W] = 64'(i + 1);
        do_write(20, '1, d);
        do_read(5, q1, qv1, q2, qv2);
        n_checks++;
        if (qv1 !== 1'b1 || lane_of(q1, 15) !== 64'd16) begin
            n_fail++; $display("FAIL skew_row5_lane15: got qv=%b val=%h expected qv=1 val=10", qv1, lane_of(q1, 15));
        end
        n_checks++;
        if (q1 !== model_row(5)) begin
            n_fail++; $display("FAIL skew_row5_full: lane%0d got %h expected %h", diff_lane(q1, model_row(5)),
                               lane_of(q1, diff_lane(q1, model_row(5))), lane_of(model_row(5), diff_lane(q1, model_row(5))));
        end
        n_checks++;
        if (qv2 !== 1'b0 || q2 !== '0) begin
            n_fail++; $display("FAIL skew_one_cycle: got qv=%b q_nonzero=%b expected qv=0 q=0", qv2, (q2 != '0));
        end
        do_read(20, q1, qv1, q2, qv2);
        n_checks++;
        if (lane_of(q1, 0) !== 64'd1) begin
            n_fail++; $display("FAIL skew_row20_lane0: got %h expected 1", lane_of(q1, 0));
        end
        do_read(10, q1, qv1, q2, qv2);
        n_checks++;
        if (lane_of(q1, 10) !== 64'd11) begin
            n_fail++; $display("FAIL skew_row10_lane10: got %h expected b", lane_of(q1, 10));
        end
        $display("test_skew done");
    endtask

    task automatic test_wrap;
        logic [DW-1:0] d, q1, q2;
        logic qv1, qv2;
        for (int i = 0; i < LANES; i++) d[i*LANE_W +: LANE_W] = 64'hA000 + 64'(i);
        do_write(3, '1, d);
        do_read(30, q1, qv1, q2, qv2);
        n_checks++;
        if (lane_of(q1, 5) !== 64'hA005) begin
            n_fail++; $display("FAIL wrap_row30_lane5: got %h expected a005", lane_of(q1, 5));
        end
        for (int i = 0; i < LANES; i++) d[i*LANE_W +: LANE_W] = 64'hDEAD;
        d[LANE_W-1:0] = 64'hBEEF;
        do_write(3, 16'h0001, d);
        do_read(30, q1, qv1, q2, qv2);
        n_checks++;
        if (q1 !== model_row(30) || lane_of(q1, 5) !== 64'hA005) begin
            n_fail++; $display("FAIL wrap_mask_row30: lane5 got %h expected a005", lane_of(q1, 5));
        end
        do_read(3, q1, qv1, q2, qv2);
        n_checks++;
        if (lane_of(q1, 0) !== 64'hBEEF || q1 !== model_row(3)) begin
            n_fail++; $display("FAIL wrap_mask_row3: lane0 got %h expected beef", lane_of(q1, 0));
        end
        do_read(2, q1, qv1, q2, qv2);
        n_checks++;
        if (lane_of(q1, 1) !== 64'hA001) begin
            n_fail++; $display("FAIL wrap_mask_row2_lane1: got %h expected a001", lane_of(q1, 1));
        end
        $display("test_wrap done");
    endtask

    task automatic test_drain_stall;
        logic [DW-1:0] exp_rows [4];
        logic [DW-1:0] prev_q;
        logic pat [4];
        logic hold_prev;
        int k, done_cnt, c;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int j = 0; j < 4; j++) exp_rows[j] = model_row((30 + j) % DEPTH);
`ifdef OBUF_CLEAR_ON_DRAIN_EN
        for (int j = 0; j < 4; j++) model_clear(30 + j);
`endif
        DRAIN_BASE = AW'(30); DRAIN_LEN = 6'd4; DRAIN_START = 1'b1;
        tick;
        DRAIN_START = 1'b0;
        n_checks++;
        if (DRAIN_BUSY !== 1'b1) begin
            n_fail++; $display("FAIL drain_busy: got %b expected 1", DRAIN_BUSY);
        end
        k = 0; done_cnt = 0; hold_prev = 1'b0; prev_q = '0;
        for (c = 0; c < 60; c++) begin
            if (!DRAIN_BUSY) break;
            DRAIN_READY = pat[c % 4];
            if (hold_prev) begin
                n_checks++;
                if (QV !== 1'b1 || Q !== prev_q) begin
                    n_fail++; $display("FAIL drain_stall_hold: got qv=%b changed=%b expected qv=1 unchanged", QV, (Q !== prev_q));
                end
            end
            if (!QV) begin
                n_checks++;
                if (Q !== '0) begin
                    n_fail++; $display("FAIL drain_q_idle: got nonzero lane0=%h expected 0", lane_of(Q, 0));
                end
            end
            if (DRAIN_DONE) done_cnt++;
            if (QV && DRAIN_READY) begin
                n_checks++;
                if (k >= 4 || Q !== exp_rows[k % 4]) begin
                    n_fail++; $display("FAIL drain_beat%0d: got lane0=%h expected lane0=%h", k, lane_of(Q, 0), lane_of(exp_rows[k % 4], 0));
                end
                $display("drain beat %0d accepted lane0=%h", k, lane_of(Q, 0));
                k++;
            end
            hold_prev = QV && !DRAIN_READY;
            prev_q = Q;
            tick;
        end
        DRAIN_READY = 1'b0;
        tick; tick;
        n_checks++;
        if (c >= 60 || k != 4 || done_cnt != 1) begin
            n_fail++; $display("FAIL drain_summary: got beats=%0d done_pulses=%0d cycles=%0d expected 4 1 <60", k, done_cnt, c);
        end
        n_checks++;
        if (QV !== 1'b0 || DRAIN_BUSY !== 1'b0 || DRAIN_DONE !== 1'b0) begin
            n_fail++; $display("FAIL drain_after: got qv=%b busy=%b done=%b expected 0 0 0", QV, DRAIN_BUSY, DRAIN_DONE);
        end
    endtask

    task automatic test_drain_zero;
        DRAIN_LEN = '0; DRAIN_BASE = AW'(7); DRAIN_START = 1'b1;
        tick;
        DRAIN_START = 1'b0;
        n_checks++;
        if (DRAIN_DONE !== 1'b1 || DRAIN_BUSY !== 1'b1 || QV !== 1'b0) begin
            n_fail++; $display("FAIL zero_done: got done=%b busy=%b qv=%b expected 1 1 0", DRAIN_DONE, DRAIN_BUSY, QV);
        end
        tick;
        n_checks++;
        if (DRAIN_DONE !== 1'b0 || DRAIN_BUSY !== 1'b0 || QV !== 1'b0) begin
            n_fail++; $display("FAIL zero_after: got done=%b busy=%b qv=%b expected 0 0 0", DRAIN_DONE, DRAIN_BUSY, QV);
        end
        $display("test_drain_zero done");
    endtask

    task automatic test_busy_ignore;
        logic [DW-1:0] row4, row5, d, q1, q2;
        logic qv1, qv2;
        row4 = model_row(4); row5 = model_row(5);
`ifdef OBUF_CLEAR_ON_DRAIN_EN
        model_clear(4); model_clear(5);
`endif
        DRAIN_BASE = AW'(4); DRAIN_LEN = 6'd2; DRAIN_READY = 1'b0; DRAIN_START = 1'b1;
        tick;
        DRAIN_START = 1'b0;
        tick;
        n_checks++;
        if (QV !== 1'b1 || Q !== row4) begin
            n_fail++; $display("FAIL busy_first: got qv=%b lane0=%h expected 1 %h", QV, lane_of(Q, 0), lane_of(row4, 0));
        end
        CEN = 1'b0; WEN = 1'b1; A = AW'(20);
        DRAIN_START = 1'b1; DRAIN_BASE = AW'(10); DRAIN_LEN = 6'd5;
        tick;
        CEN = 1'b1; DRAIN_START = 1'b0;
        d = '0; d[LANE_W-1:0] = 64'h5A5A;
        do_write(10, 16'h0001, d);
        n_checks++;
        if (QV !== 1'b1 || Q !== row4) begin
            n_fail++; $display("FAIL busy_ignore_hold: got qv=%b lane0=%h expected 1 %h", QV, lane_of(Q, 0), lane_of(row4, 0));
        end
        DRAIN_READY = 1'b1;
        tick;
        n_checks++;
        if (QV !== 1'b1 || Q !== row5) begin
            n_fail++; $display("FAIL busy_second: got qv=%b lane0=%h expected 1 %h", QV, lane_of(Q, 0), lane_of(row5, 0));
        end
        tick;
        n_checks++;
        if (DRAIN_DONE !== 1'b1 || QV !== 1'b0) begin
            n_fail++; $display("FAIL busy_done: got done=%b qv=%b expected 1 0", DRAIN_DONE, QV);
        end
        DRAIN_READY = 1'b0;
        tick; tick;
        n_checks++;
        if (DRAIN_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL busy_no_restart: got busy=%b expected 0", DRAIN_BUSY);
        end
        do_read(10, q1, qv1, q2, qv2);
        n_checks++;
        if (lane_of(q1, 0) !== 64'h5A5A) begin
            n_fail++; $display("FAIL busy_write_landed: got %h expected 5a5a", lane_of(q1, 0));
        end
        $display("test_busy_ignore done");
    endtask

    task automatic test_reset_mid_drain;
        logic [DW-1:0] q1, q2, row10;
        logic qv1, qv2;
        int seen;
        row10 = model_row(10);
`ifdef OBUF_CLEAR_ON_DRAIN_EN
        model_clear(8); model_clear(9); model_clear(10);
`endif
        DRAIN_BASE = AW'(8); DRAIN_LEN = 6'd8; DRAIN_READY = 1'b1; DRAIN_START = 1'b1;
        tick;
        DRAIN_START = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (QV) seen++;
            if (seen == 3) break;
            tick;
        end
        n_checks++;
        if (seen != 3 || Q !== row10) begin
            n_fail++; $display("FAIL middrain_third: got seen=%0d lane0=%h expected 3 %h", seen, lane_of(Q, 0), lane_of(row10, 0));
        end
        RETN = 1'b0;
        #1;
        n_checks++;
        if (Q !== '0 || QV !== 1'b0 || DRAIN_BUSY !== 1'b0 || DRAIN_DONE !== 1'b0) begin
            n_fail++; $display("FAIL middrain_async: got qv=%b busy=%b done=%b q_nonzero=%b expected all 0",
                               QV, DRAIN_BUSY, DRAIN_DONE, (Q != '0));
        end
        DRAIN_READY = 1'b0;
        tick; tick;
        RETN = 1'b1;
        tick;
        for (int r = 8; r < 16; r++) begin
            do_read(r, q1, qv1, q2, qv2);
            n_checks++;
            if (qv1 !== 1'b1 || q1 !== model_row(r)) begin
                n_fail++; $display("FAIL middrain_mem_row%0d: got qv=%b lane0=%h expected 1 %h", r, qv1, lane_of(q1, 0), model[r][0]);
            end
        end
        $display("test_reset_mid_drain done");
    endtask

    task automatic test_clear;
        logic [DW-1:0] q1, q2, exp2;
        logic qv1, qv2;
        int c;
`ifdef OBUF_CLEAR_ON_DRAIN_EN
        for (int j = 0; j < 4; j++) model_clear(j);
        exp2 = '0;
`else
        exp2 = model_row(2);
`endif
        DRAIN_BASE = '0; DRAIN_LEN = 6'd4; DRAIN_READY = 1'b1; DRAIN_START = 1'b1;
        tick;
        DRAIN_START = 1'b0;
        for (c = 0; c < 30; c++) begin
            if (!DRAIN_BUSY) break;
            tick;
        end
        DRAIN_READY = 1'b0;
        n_checks++;
        if (c >= 30) begin
            n_fail++; $display("FAIL clear_timeout: got busy after %0d cycles expected idle", c);
        end
        do_read(2, q1, qv1, q2, qv2);
        n_checks++;
        if (q1 !== exp2) begin
            n_fail++; $display("FAIL clear_row2: lane%0d got %h expected %h", diff_lane(q1, exp2),
                               lane_of(q1, diff_lane(q1, exp2)), lane_of(exp2, diff_lane(q1, exp2)));
        end
        $display("test_clear done: row2 lane1=%h", lane_of(q1, 1));
    endtask

    initial begin
        test_reset;
        test_fill;
        test_skew;
        test_wrap;
        test_drain_stall;
        test_drain_zero;
        test_busy_ignore;
        test_reset_mid_drain;
        test_clear;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
